// File: rtl/sram_pkg.sv
// Shared defaults and types for the external SRAM responder.
// Holds the read-FSM state encoding and the stall LFSR feedback taps.
package sram_pkg;
  localparam int SRAM_ADDR_W = 26;
  localparam int SRAM_DATA_W = 32;

  // x^16 + x^14 + x^13 + x^11 + 1 expressed as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rd_state_e;
endpackage

// File: rtl/sram_stall_lfsr.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random write backpressure.
// Shifts left; the feedback bit enters at bit 0.
module sram_stall_lfsr
  import sram_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);
  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
endmodule

// File: rtl/ext_sram_responder.sv
// Memory-side responder for the Genie external-memory interface: a word array
// behind a write channel with optional pseudo-random backpressure and a fixed-latency read FSM.
module ext_sram_responder
  import sram_pkg::*;
#(
  parameter int          ADDR_W    = SRAM_ADDR_W,
  parameter int          DATA_W    = SRAM_DATA_W,
  parameter int          MEM_AW    = 16,
  parameter int          READ_LAT  = 2,
  parameter int          STALL_EN  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wvalid,
  output logic              wready,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       rd_cnt
);
  localparam int         DEPTH  = 1 << MEM_AW;
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  rd_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              rready_q, rready_d;
  logic              wready_q, wready_d;
  logic [DATA_W-1:0] rdata_q;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [15:0]       lfsr_state;
  logic              wr_fire;
  logic              rd_sample;
  logic [MEM_AW-1:0] waddr_idx;
  logic [MEM_AW-1:0] rd_idx;
  logic              unused_bits;

  logic [DATA_W-1:0] mem [DEPTH];

  sram_stall_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (STALL_EN != 0),
    .state (lfsr_state)
  );

  // Address bits above MEM_AW alias onto the same word.
  assign unused_bits = ^{raddr[ADDR_W-1:MEM_AW], waddr[ADDR_W-1:MEM_AW], lfsr_state[15:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (rvalid) begin
          addr_d  = raddr[MEM_AW-1:0];
          cnt_d   = LAT_M1;
          state_d = (READ_LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rready_d  = (state_d == RESP);
    rd_sample = (state_d == RESP) && (state_q != RESP);
    rd_idx    = (state_q == IDLE) ? raddr[MEM_AW-1:0] : addr_q;
    wr_fire   = wvalid && wready_q;
    waddr_idx = waddr[MEM_AW-1:0];
    wready_d  = (STALL_EN == 0) || (lfsr_state[1:0] != 2'b11);
    wr_cnt_d  = wr_cnt_q + {31'd0, wr_fire};
    rd_cnt_d  = rd_cnt_q + {31'd0, state_q == RESP};
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[waddr_idx] <= wdata;
    end
  end

  // A write landing on the same edge as the sample wins over the stored word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_sample) begin
      rdata_q <= (wr_fire && (waddr_idx == rd_idx)) ? wdata : mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rready_q <= 1'b0;
      wready_q <= 1'b0;
      wr_cnt_q <= 32'd0;
      rd_cnt_q <= 32'd0;
    end else begin
      rready_q <= rready_d;
      wready_q <= wready_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wready = wready_q;
  assign rready = rready_q;
  assign rdata  = rdata_q;
  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
endmodule

// File: tb/tb_ext_sram_responder.sv
// Bench for ext_sram_responder: three instances (latency 2, latency 1, latency 8 with stalls)
// driven with directed and random traffic and compared against a word-array reference model.
`timescale 1ns/1ps
module tb_ext_sram_responder;
  localparam int NDUT = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 8;
  endfunction

  function automatic int stall_of(int d);
    return (d == 2) ? 1 : 0;
  endfunction

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, new bit shifted in at the bottom.
  function automatic logic [15:0] lfsr_next(logic [15:0] s);
    int   taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[k]) fb ^= s[taps[k] - 1];
    return {s[14:0], fb};
  endfunction

  logic        clk = 1'b0;
  logic        rst_n  [NDUT];
  logic        wvalid [NDUT];
  logic        wready [NDUT];
  logic [25:0] waddr  [NDUT];
  logic [31:0] wdata  [NDUT];
  logic        rvalid [NDUT];
  logic        rready [NDUT];
  logic [25:0] raddr  [NDUT];
  logic [31:0] rdata  [NDUT];
  logic [31:0] wr_cnt [NDUT];
  logic [31:0] rd_cnt [NDUT];

  bit [31:0]   ref_mem [NDUT][65536];
  bit          seen    [NDUT][65536];
  int unsigned exp_wr  [NDUT];
  int unsigned exp_rd  [NDUT];
  bit          exp_wready [NDUT];
  logic [15:0] lfsr_m  [NDUT];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      ext_sram_responder #(
        .READ_LAT (lat_of(gi)),
        .STALL_EN (stall_of(gi))
      ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n[gi]),
        .wvalid (wvalid[gi]),
        .wready (wready[gi]),
        .waddr  (waddr[gi]),
        .wdata  (wdata[gi]),
        .rvalid (rvalid[gi]),
        .rready (rready[gi]),
        .raddr  (raddr[gi]),
        .rdata  (rdata[gi]),
        .wr_cnt (wr_cnt[gi]),
        .rd_cnt (rd_cnt[gi])
      );

      // wready for the coming cycle is decided by the LFSR value before the edge.
      always @(posedge clk or negedge rst_n[gi]) begin
        if (!rst_n[gi]) begin
          lfsr_m[gi]     = SEED;
          exp_wready[gi] = 1'b0;
        end else begin
          exp_wready[gi] = (stall_of(gi) == 0) || (lfsr_m[gi][1:0] != 2'b11);
          lfsr_m[gi]     = lfsr_next(lfsr_m[gi]);
        end
      end

      always @(negedge clk) begin
        if (rst_n[gi] !== 1'bx) begin
          chk($sformatf("wready%0d", gi), {31'd0, wready[gi]}, {31'd0, exp_wready[gi]});
        end
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves wvalid asserted so callers can stream writes back to back.
  task automatic do_write(int d, logic [25:0] a, logic [31:0] v);
    int n = 0;
    wvalid[d] = 1'b1;
    waddr[d]  = a;
    wdata[d]  = v;
    while (!wready[d] && n < 64) begin
      tick();
      n++;
    end
    chk("wr_accept", {31'd0, wready[d]}, 32'd1);
    tick();
    if (n < 64) begin
      ref_mem[d][a[15:0]] = v;
      seen[d][a[15:0]]    = 1'b1;
      exp_wr[d]++;
    end
    chk("wr_cnt", wr_cnt[d], exp_wr[d]);
    $display("wr  dut=%0d addr=%h data=%h stall=%0d", d, a, v, n);
  endtask

  task automatic do_read(int d, logic [25:0] a, bit hold);
    int          n = 0;
    logic [31:0] expv;
    expv      = ref_mem[d][a[15:0]];
    rvalid[d] = 1'b1;
    raddr[d]  = a;
    do begin
      tick();
      n++;
    end while (!rready[d] && n < 40);
    chk("rd_latency", n, lat_of(d));
    chk("rd_data", rdata[d], expv);
    if (!hold) rvalid[d] = 1'b0;
    exp_rd[d]++;
    tick();
    chk("rd_pulse", {31'd0, rready[d]}, 32'd0);
    chk("rd_hold", rdata[d], expv);
    chk("rd_cnt", rd_cnt[d], exp_rd[d]);
    $display("rd  dut=%0d addr=%h data=%h lat=%0d", d, a, rdata[d], n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] a;
    logic [15:0] lo;
    int          nrst;
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d]  = 1'b1;
      wvalid[d] = 1'b0;
      rvalid[d] = 1'b0;
      waddr[d]  = '0;
      raddr[d]  = '0;
      wdata[d]  = '0;
    end
    #2;
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_rready", {31'd0, rready[d]}, 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_wr_cnt", wr_cnt[d], 32'd0);
      chk("rst_rd_cnt", rd_cnt[d], 32'd0);
      rst_n[d] = 1'b1;
    end
    tick();

    // Basic write then read, latency 2.
    do_write(0, 26'h10, 32'hDEADBEEF);
    wvalid[0] = 1'b0;
    do_read(0, 26'h10, 1'b0);

    // Aliasing above bit 16.
    do_write(0, 26'h10005, 32'hA5A5A5A5);
    wvalid[0] = 1'b0;
    do_read(0, 26'h00005, 1'b0);

    // Write on the same edge that enters RESP must be returned.
    do_write(0, 26'h20, 32'h0);
    wvalid[0] = 1'b0;
    tick();
    rvalid[0] = 1'b1;
    raddr[0]  = 26'h20;
    tick();
    wvalid[0] = 1'b1;
    waddr[0]  = 26'h20;
    wdata[0]  = 32'h12345678;
    tick();
    wvalid[0] = 1'b0;
    rvalid[0] = 1'b0;
    ref_mem[0][16'h20] = 32'h12345678;
    exp_wr[0]++;
    exp_rd[0]++;
    chk("haz_rready", {31'd0, rready[0]}, 32'd1);
    chk("haz_rdata", rdata[0], 32'h12345678);
    tick();
    chk("haz_rd_cnt", rd_cnt[0], exp_rd[0]);
    chk("haz_wr_cnt", wr_cnt[0], exp_wr[0]);
    $display("rd  dut=0 addr=%h data=%h hazard", 26'h20, rdata[0]);

    // Latency 1, back-to-back reads with rvalid held across responses.
    for (int i = 0; i < 8; i++) do_write(1, 26'(i), 32'(i * 3));
    wvalid[1] = 1'b0;
    for (int i = 0; i < 8; i++) do_read(1, 26'(i), 1'b1);
    rvalid[1] = 1'b0;
    chk("b2b_rd_cnt", rd_cnt[1], 32'd8);

    // Random mixed traffic on the two unstalled instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        lo = 16'($urandom_range(0, 63));
        a  = {10'($urandom), lo};
        if (!seen[d][lo] || ($urandom_range(0, 1) == 0)) begin
          do_write(d, a, $urandom);
          wvalid[d] = 1'b0;
        end else begin
          do_read(d, a, 1'b0);
        end
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    // Stalled instance: 1000 streamed writes, then spot-check readback.
    for (int i = 0; i < 1000; i++) begin
      do_write(2, {10'($urandom), 16'($urandom_range(0, 255))}, $urandom);
    end
    wvalid[2] = 1'b0;
    chk("stall_wr_cnt", wr_cnt[2], 32'd1000);
    for (int i = 0; i < 16; i++) begin
      lo = 16'($urandom_range(0, 255));
      if (seen[2][lo]) do_read(2, {10'($urandom), lo}, 1'b0);
    end

    // Reset in the middle of a latency-8 read: the response must never appear.
    lo = 16'h0;
    for (int k = 0; k < 256; k++) if (seen[2][k]) lo = 16'(k);
    rvalid[2] = 1'b1;
    raddr[2]  = {10'd0, lo};
    tick();
    tick();
    tick();
    rst_n[2]  = 1'b0;
    rvalid[2] = 1'b0;
    #1;
    chk("rst_mid_rready", {31'd0, rready[2]}, 32'd0);
    tick();
    tick();
    rst_n[2] = 1'b1;
    exp_rd[2] = 0;
    exp_wr[2] = 0;
    nrst = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rready[2]) nrst++;
    end
    chk("rst_no_resp", nrst, 0);
    chk("rst_rd_cnt", rd_cnt[2], 32'd0);
    chk("rst_wr_cnt2", wr_cnt[2], 32'd0);
    do_read(2, {10'd0, lo}, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
